// File: rtl/writeback_stage_if.sv
// Memory-stage to writeback-stage bundle: captured stage inputs plus
// register-file write port and forwarding outputs.
interface writeback_stage_if;
  logic        valid_in;
  logic [15:0] ir_in;
  logic [15:0] alu_out_in;
  logic [15:0] mem_data_in;
  logic [15:0] pc_inc_in;
  logic        rf_write_in;
  logic        ccr_write_in;
  logic        carry_in;
  logic        zero_in;

  logic        rf_we;
  logic [2:0]  rf_wa;
  logic [15:0] rf_wd;
  logic        r7_write;
  logic [15:0] ir_out;
  logic        ccr_write_out;
  logic        valid_out;

  modport master (
    output valid_in, ir_in, alu_out_in, mem_data_in, pc_inc_in,
           rf_write_in, ccr_write_in, carry_in, zero_in,
    input  rf_we, rf_wa, rf_wd, r7_write, ir_out, ccr_write_out, valid_out
  );

  modport slave (
    input  valid_in, ir_in, alu_out_in, mem_data_in, pc_inc_in,
           rf_write_in, ccr_write_in, carry_in, zero_in,
    output rf_we, rf_wa, rf_wd, r7_write, ir_out, ccr_write_out, valid_out
  );
endinterface

// File: rtl/writeback_stage.sv
// RISC15 writeback stage: registers memory-stage results, drives the
// register-file write port and retires the architectural carry/zero flags.
module writeback_stage (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  writeback_stage_if.slave  wb,
  output logic              carry_flag,
  output logic              zero_flag
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_ADI = 4'b0001,
    OP_NDU = 4'b0010,
    OP_LHI = 4'b0011,
    OP_LW  = 4'b0100,
    OP_SW  = 4'b0101,
    OP_LM  = 4'b0110,
    OP_SM  = 4'b0111,
    OP_JAL = 4'b1000,
    OP_JLR = 4'b1001,
    OP_BEQ = 4'b1100
  } opcode_e;

  typedef enum logic [1:0] {
    WD_ALU,
    WD_MEM,
    WD_PC
  } wd_sel_e;

  logic        valid_q;
  logic [15:0] ir_q;
  logic [15:0] alu_q;
  logic [15:0] mem_q;
  logic [15:0] pc_inc_q;
  logic        rf_write_q;
  logic        ccr_write_q;
  logic        carry_q;
  logic        zero_q;

  opcode_e     opcode;
  logic        op_writes;
  logic [2:0]  dest;
  wd_sel_e     wd_sel;
  logic        live;
  logic        we;
  logic        advance;

  // Flush outranks stall, so a flushed stage still advances and retires its holder.
  assign advance = flush | ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      ir_q        <= '0;
      alu_q       <= '0;
      mem_q       <= '0;
      pc_inc_q    <= '0;
      rf_write_q  <= 1'b0;
      ccr_write_q <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else if (advance) begin
      valid_q     <= wb.valid_in & ~flush;
      ir_q        <= wb.ir_in;
      alu_q       <= wb.alu_out_in;
      mem_q       <= wb.mem_data_in;
      pc_inc_q    <= wb.pc_inc_in;
      rf_write_q  <= wb.rf_write_in;
      ccr_write_q <= wb.ccr_write_in;
      carry_q     <= wb.carry_in;
      zero_q      <= wb.zero_in;
    end
  end

  assign opcode = opcode_e'(ir_q[15:12]);

  always_comb begin
    op_writes = 1'b0;
    dest      = ir_q[11:9];
    wd_sel    = WD_ALU;
    case (opcode)
      OP_ADD, OP_NDU: begin
        op_writes = 1'b1;
        dest      = ir_q[5:3];
      end
      OP_ADI: begin
        op_writes = 1'b1;
        dest      = ir_q[8:6];
      end
      OP_LHI: op_writes = 1'b1;
      OP_LW: begin
        op_writes = 1'b1;
        wd_sel    = WD_MEM;
      end
      OP_JAL, OP_JLR: begin
        op_writes = 1'b1;
        wd_sel    = WD_PC;
      end
      default: op_writes = 1'b0;
    endcase
  end

  // The write port is gated by reset so nothing is written in the reset cycle.
  assign live = valid_q & ~reset;
  assign we   = live & rf_write_q & op_writes;

  always_comb begin
    case (wd_sel)
      WD_MEM:  wb.rf_wd = mem_q;
      WD_PC:   wb.rf_wd = pc_inc_q;
      default: wb.rf_wd = alu_q;
    endcase
  end

  assign wb.rf_we         = we;
  assign wb.rf_wa         = dest;
  assign wb.r7_write      = we & (dest == 3'd7);
  assign wb.ir_out        = ir_q;
  assign wb.ccr_write_out = live & ccr_write_q;
  assign wb.valid_out     = live;

  // Flags retire from the stage register on the edge the instruction leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else if (advance && valid_q && ccr_write_q) begin
      case (opcode)
        OP_ADD, OP_ADI: begin
          carry_flag <= carry_q;
          zero_flag  <= zero_q;
        end
        OP_NDU: zero_flag <= zero_q;
        OP_LW:  zero_flag <= (mem_q == '0);
        default: begin
          carry_flag <= carry_flag;
          zero_flag  <= zero_flag;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed-vector bench for writeback_stage: stimulus pushes expected
// post-edge outputs into a queue, a monitor pops and compares every cycle.
module tb_writeback_stage;

  logic clk;
  logic reset;
  logic stall;
  logic flush;
  logic carry_flag;
  logic zero_flag;

  writeback_stage_if wb ();

  writeback_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .wb         (wb.slave),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag)
  );

  typedef struct {
    string       name;
    logic        v;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        r7;
    logic [15:0] ir;
    logic        m_ir;
    logic        ccrw;
    logic        c;
    logic        z;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per cycle, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        ok = (wb.valid_out === e.v) && (wb.rf_we === e.we) &&
             (wb.r7_write === e.r7) && (wb.ccr_write_out === e.ccrw) &&
             (carry_flag === e.c) && (zero_flag === e.z);
        if (e.we && ((wb.rf_wa !== e.wa) || (wb.rf_wd !== e.wd))) ok = 1'b0;
        if (e.m_ir && (wb.ir_out !== e.ir)) ok = 1'b0;
        n_cmp++;
        if (!ok) begin
          n_bad++;
          $display("FAIL %s: got v=%b we=%b wa=%0d wd=%h r7=%b ir=%h ccrw=%b C=%b Z=%b, want v=%b we=%b wa=%0d wd=%h r7=%b ir=%h ccrw=%b C=%b Z=%b",
                   e.name, wb.valid_out, wb.rf_we, wb.rf_wa, wb.rf_wd, wb.r7_write,
                   wb.ir_out, wb.ccr_write_out, carry_flag, zero_flag,
                   e.v, e.we, e.wa, e.wd, e.r7, e.ir, e.ccrw, e.c, e.z);
        end
      end
    end
  end

  task automatic step(
    input string       nm,
    input logic        rst, stl, fl, v,
    input logic [15:0] ir, alu, mem, pc,
    input logic        rfw, ccr, c, z,
    input logic        ev, ewe,
    input logic [2:0]  ewa,
    input logic [15:0] ewd,
    input logic        er7,
    input logic [15:0] eir,
    input logic        mir, eccr, ec, ez
  );
    exp_t e;
    reset              = rst;
    stall              = stl;
    flush              = fl;
    wb.valid_in        = v;
    wb.ir_in           = ir;
    wb.alu_out_in      = alu;
    wb.mem_data_in     = mem;
    wb.pc_inc_in       = pc;
    wb.rf_write_in     = rfw;
    wb.ccr_write_in    = ccr;
    wb.carry_in        = c;
    wb.zero_in         = z;
    e.name = nm; e.v = ev; e.we = ewe; e.wa = ewa; e.wd = ewd; e.r7 = er7;
    e.ir = eir; e.m_ir = mir; e.ccrw = eccr; e.c = ec; e.z = ez;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int budget;
    //         name        rst stl fl v  ir        alu       mem       pc        rfw ccr c  z    ev we wa  wd        r7 ir        mir ccw C  Z
    step("reset0",       1, 0, 0, 1, 16'h0298, 16'h1111, 16'h2222, 16'h3333, 1, 1, 1, 1,  0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0);
    step("reset1",       1, 0, 0, 1, 16'h0298, 16'h1111, 16'h2222, 16'h3333, 1, 1, 1, 1,  0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0);
    step("add_r3",       0, 0, 0, 1, 16'h0298, 16'h0000, 16'h7777, 16'h0005, 1, 1, 1, 1,  1, 1, 3, 16'h0000, 0, 16'h0298, 1, 1, 0, 0);
    step("lw_r5_zero",   0, 0, 0, 1, 16'h4A00, 16'hFFFF, 16'h0000, 16'h0006, 1, 1, 0, 0,  1, 1, 5, 16'h0000, 0, 16'h4A00, 1, 1, 1, 1);
    step("lw_r5_nz",     0, 0, 0, 1, 16'h4A00, 16'h0000, 16'h1234, 16'h0007, 1, 1, 0, 1,  1, 1, 5, 16'h1234, 0, 16'h4A00, 1, 1, 1, 1);
    step("jal_r7",       0, 0, 0, 1, 16'h8E05, 16'h5555, 16'hAAAA, 16'h0011, 1, 0, 0, 1,  1, 1, 7, 16'h0011, 1, 16'h8E05, 1, 0, 1, 0);
    step("adi_r4",       0, 0, 0, 1, 16'h1103, 16'h0000, 16'h9999, 16'h0012, 1, 1, 0, 1,  1, 1, 4, 16'h0000, 0, 16'h1103, 1, 1, 1, 0);
    step("stall_a",      0, 1, 0, 1, 16'h0298, 16'hBEEF, 16'h0000, 16'h0013, 1, 1, 1, 0,  1, 1, 4, 16'h0000, 0, 16'h1103, 1, 1, 1, 0);
    step("stall_b",      0, 1, 0, 1, 16'h0298, 16'hBEEF, 16'h0000, 16'h0013, 1, 1, 1, 0,  1, 1, 4, 16'h0000, 0, 16'h1103, 1, 1, 1, 0);
    step("stall_c",      0, 1, 0, 1, 16'h0298, 16'hBEEF, 16'h0000, 16'h0013, 1, 1, 1, 0,  1, 1, 4, 16'h0000, 0, 16'h1103, 1, 1, 1, 0);
    step("ndu_r6",       0, 0, 0, 1, 16'h2070, 16'hABCD, 16'h0000, 16'h0014, 1, 1, 1, 0,  1, 1, 6, 16'hABCD, 0, 16'h2070, 1, 1, 0, 1);
    step("sw_hold",      0, 0, 0, 1, 16'h5A00, 16'h0044, 16'h0000, 16'h0015, 0, 0, 1, 1,  1, 0, 0, 16'h0000, 0, 16'h5A00, 1, 0, 0, 0);
    step("flush_stall",  0, 1, 1, 1, 16'h4A00, 16'h0000, 16'h0000, 16'h0016, 1, 1, 1, 1,  0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
    step("add_nottaken", 0, 0, 0, 1, 16'h0298, 16'h0001, 16'h0000, 16'h0017, 0, 0, 1, 1,  1, 0, 0, 16'h0000, 0, 16'h0298, 1, 0, 0, 0);
    step("sw",           0, 0, 0, 1, 16'h5A00, 16'h0020, 16'h0000, 16'h0018, 1, 0, 1, 1,  1, 0, 0, 16'h0000, 0, 16'h5A00, 1, 0, 0, 0);
    step("idle",         0, 0, 0, 0, 16'h0298, 16'h0000, 16'h0000, 16'h0019, 1, 1, 1, 1,  0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
    step("add_c",        0, 0, 0, 1, 16'h0298, 16'h8000, 16'h0000, 16'h001A, 1, 1, 1, 0,  1, 1, 3, 16'h8000, 0, 16'h0298, 1, 1, 0, 0);
    step("jal_r7_b",     0, 0, 0, 1, 16'h8E05, 16'h0000, 16'h0000, 16'h0042, 1, 0, 0, 0,  1, 1, 7, 16'h0042, 1, 16'h8E05, 1, 0, 1, 0);
    step("reset_stall",  1, 1, 0, 1, 16'h0298, 16'h0000, 16'h0000, 16'h0043, 1, 1, 1, 1,  0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0);
    step("post_reset",   0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0);

    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the RISC15 core, directly downstream of the memory-access stage. Registers the memory-stage results (load data, ALU result, incremented PC, instruction word), decodes the destination register, selects the writeback data, and drives the register-file write port. Holds the architectural carry/zero flags and exports the registered instruction and CCR-write status that the memory-stage forwarding unit consumes.

## Interface
- No parameters; data width fixed at 16, register index 3 bits.
- Clock `clk` and reset `reset` (the codebase's names): one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hold the stage register and flags
- flush  in  1  squash the incoming instruction (bubble)
- valid_in  in  1  memory stage holds a real instruction
- ir_in  in  16  instruction word from the memory stage
- alu_out_in  in  16  ALU result carried through the memory stage
- mem_data_in  in  16  data-memory read data
- pc_inc_in  in  16  incremented PC (link value)
- rf_write_in  in  1  upstream writeback enable, conditional execution already resolved
- ccr_write_in  in  1  instruction updates flags
- carry_in  in  1  carry from EX
- zero_in  in  1  zero from EX
- rf_we  out  1  register-file write enable
- rf_wa  out  3  destination register
- rf_wd  out  16  writeback data
- r7_write  out  1  this write targets R7 (PC)
- carry_flag  out  1  architectural C
- zero_flag  out  1  architectural Z
- ir_out  out  16  registered instruction (to forwarding)
- ccr_write_out  out  1  registered, valid-gated ccr_write (to forwarding)
- valid_out  out  1  stage holds a real instruction

## Operation
- Stage register captures ir, alu_out, mem_data, pc_inc, rf_write, ccr_write, carry, zero and valid on each edge unless stalled.
- Opcode is ir[15:12]. Destination: ADD 0000 and NDU 0010 use ir[5:3]; ADI 0001 uses ir[8:6]; LHI 0011, LW 0100, JAL 1000 and JLR 1001 use ir[11:9]. SW, LM, SM, BEQ and unknown opcodes have no writeback. LM is sequenced upstream as a series of LW-equivalent operations.
- rf_wd: LW → mem_data; JAL/JLR → pc_inc; all other writing opcodes → alu_out.
- rf_we = valid_out & rf_write & (opcode writes). r7_write = rf_we & (rf_wa == 7).
- Flag state: the flags update one cycle after capture, at the edge that retires the instruction, and only when valid & ccr_write.
  - ADD/ADI: C ← carry, Z ← zero.
  - NDU: Z ← zero; C is unchanged.
  - LW: Z ← (mem_data == 0); C is unchanged.
- ccr_write_out = valid_out & registered ccr_write.
- Outputs are combinational from the stage register; flags are registered.

## Timing
- Reset: all stage registers, valid_out, rf_we, r7_write, carry_flag, zero_flag and ccr_write_out are 0; ir_out and rf_wd are 16'h0000; rf_wa is 0.
- Latency: inputs present at edge N appear on rf_* at cycle N (after edge N). The register file writes at edge N+1. Flags change at edge N+1.
- Stall: the stage register and flags hold, and no flag update occurs. rf_we stays asserted while held; the register-file write is idempotent.
- Flush: at the next edge valid becomes 0 and the other fields are don't-care. Flush has priority over stall.
- Reset has priority over flush and stall. Reset mid-stall discards the held instruction, and no write is issued in the reset cycle.
- Back-to-back flag writers: each updates the flags on its own retire edge. The later instruction's value wins, with no merging.

## Test plan
- Reset: assert reset for 2 cycles with valid_in=1 → rf_we=0, carry_flag=0, zero_flag=0, ir_out=0000, ccr_write_out=0.
- ADD R3←R1+R2 (ir=0x0298), alu_out=0x0000, carry_in=1, zero_in=1, ccr_write_in=1 → next cycle rf_we=1, rf_wa=3, rf_wd=0x0000; after the following edge C=1, Z=1.
- LW R5 (ir=0x4A00) with mem_data=0x0000, then LW with mem_data=0x1234 → rf_wd=0x0000 with Z=1, then rf_wd=0x1234 with Z=0; C unchanged through both.
- JAL R7 (ir=0x8E05), pc_inc=0x0011 → rf_wa=7, rf_wd=0x0011, r7_write=1, flags unchanged.
- Stall held 3 cycles mid-ADI R4 → outputs stable and flags updated once only. Flush and stall asserted together → valid_out=0 next cycle.
- rf_write_in=0 on ADD (conditional not taken), then SW → rf_we=0 both cycles, no flag update, ccr_write_out=0.
